// File: rtl/matriz_serializador.sv
// rtl/matriz_serializador.sv - streams a packed DIM x DIM matrix to memory one element per beat
//
// Purpose: captures a flat result matrix from the arithmetic units and writes
// it out over a valid/ready port, in row-major or column-major order.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a write-out (honoured only when idle)
//   col_major  order select captured with start (0 row-major, 1 column-major)
//   base_addr  first memory address, captured with start
//   matriz_in  packed source matrix, element (r,c) at [(DIM*ELEM_W*r)+(ELEM_W*c) +: ELEM_W]
//   wr_valid   write beat valid
//   wr_ready   sink accepts the beat when high together with wr_valid
//   wr_addr    address of the current beat
//   wr_data    element of the current beat
//   busy       high whenever a write-out is in progress (SEND or DONE)
//   done       one-cycle pulse after the last beat has been accepted

module matriz_serializador #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5,
    parameter int ADDR_W = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      col_major,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [DIM*DIM*ELEM_W-1:0] matriz_in,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [ELEM_W-1:0]         wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int MAT_W = DIM * DIM * ELEM_W;
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int K_W   = $clog2(DIM * DIM + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(DIM * DIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [MAT_W-1:0] shadow;
    logic             order_col;
    logic [K_W-1:0]   k;
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] c;
    logic [IDX_W-1:0] r_nxt;
    logic [IDX_W-1:0] c_nxt;

    function automatic logic [ELEM_W-1:0] elem_at(
        input logic [MAT_W-1:0] m,
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        int idx;
        idx = DIM * ELEM_W * int'(row) + ELEM_W * int'(col);
        return m[idx +: ELEM_W];
    endfunction

    // Position of the beat following the current one, in the captured order.
    always_comb begin
        r_nxt = r;
        c_nxt = c;
        if (order_col) begin
            if (r == IDX_LAST) begin
                r_nxt = '0;
                c_nxt = c + IDX_W'(1);
            end else begin
                r_nxt = r + IDX_W'(1);
            end
        end else begin
            if (c == IDX_LAST) begin
                c_nxt = '0;
                r_nxt = r + IDX_W'(1);
            end else begin
                c_nxt = c + IDX_W'(1);
            end
        end
    end

    // wr_data/wr_addr are loaded one edge ahead so the port is fully registered:
    // nothing on the output side depends combinationally on wr_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            order_col <= 1'b0;
            k         <= '0;
            r         <= '0;
            c         <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SEND;
                        shadow    <= matriz_in;
                        order_col <= col_major;
                        k         <= '0;
                        r         <= '0;
                        c         <= '0;
                        wr_valid  <= 1'b1;
                        wr_addr   <= base_addr;
                        wr_data   <= elem_at(matriz_in, '0, '0);
                        busy      <= 1'b1;
                    end
                end

                SEND: begin
                    if (wr_valid && wr_ready) begin
                        if (k == K_LAST) begin
                            state    <= FIN;
                            wr_valid <= 1'b0;
                            wr_addr  <= '0;
                            wr_data  <= '0;
                            done     <= 1'b1;
                        end else begin
                            k       <= k + K_W'(1);
                            r       <= r_nxt;
                            c       <= c_nxt;
                            // base_addr + k, wrapping silently at 2^ADDR_W
                            wr_addr <= wr_addr + ADDR_W'(1);
                            wr_data <= elem_at(shadow, r_nxt, c_nxt);
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    k     <= '0;
                    r     <= '0;
                    c     <= '0;
                end

                default: begin
                    state    <= IDLE;
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matriz_serializador.sv
// tb/tb_matriz_serializador.sv - directed self-checking bench for matriz_serializador

module tb_matriz_serializador;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int ADDR_W = 9;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic                      col_major;
    logic [ADDR_W-1:0]         base_addr;
    logic [DIM*DIM*ELEM_W-1:0] matriz_in;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_addr;
    logic [ELEM_W-1:0]         wr_data;
    logic                      busy;
    logic                      done;

    logic [DIM*DIM*ELEM_W-1:0] mat_a;
    logic [DIM*DIM*ELEM_W-1:0] mat_b;

    int checks   = 0;
    int failures = 0;

    matriz_serializador #(
        .ELEM_W(ELEM_W),
        .DIM   (DIM),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .col_major(col_major),
        .base_addr(base_addr),
        .matriz_in(matriz_in),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected element value for beat i: matrix a holds 10*r+c at (r,c).
    function automatic int exp_data(input bit col, input int i);
        int rr;
        int cc;
        rr = col ? (i % DIM) : (i / DIM);
        cc = col ? (i / DIM) : (i % DIM);
        return 10 * rr + cc;
    endfunction

    task automatic pulse_start(input bit col, input logic [ADDR_W-1:0] base);
        @(negedge clk);
        start     = 1'b1;
        col_major = col;
        base_addr = base;
        matriz_in = mat_a;
        @(posedge clk);
        #1;
        start     = 1'b0;
        matriz_in = mat_b;
        base_addr = 9'h155;
    endtask

    // bp: ready follows 1,0,0,1; inject: a second start with other inputs at beat 7.
    task automatic run_stream(input bit col, input logic [ADDR_W-1:0] base,
                              input bit bp, input bit inject, input bit timing);
        int  beats;
        int  dones;
        int  busy_cyc;
        bit  seen_done;
        bit  injected;
        bit  prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [ELEM_W-1:0] prev_data;
        bit  rdy;
        beats = 0; dones = 0; busy_cyc = 0; seen_done = 0; injected = 0; prev_stall = 0;
        prev_addr = '0; prev_data = '0;
        pulse_start(col, base);
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            case (cyc % 4)
                0: rdy = 1'b1;
                1: rdy = 1'b0;
                2: rdy = 1'b0;
                default: rdy = 1'b1;
            endcase
            if (!bp) rdy = 1'b1;
            wr_ready = rdy;
            if (busy) busy_cyc++;
            if (wr_valid && prev_stall) begin
                check("stall_addr_hold", 32'(wr_addr), 32'(prev_addr));
                check("stall_data_hold", 32'(wr_data), 32'(prev_data));
            end
            if (wr_valid && rdy) begin
                check($sformatf("beat%0d_data", beats), 32'(wr_data), 32'(exp_data(col, beats)));
                check($sformatf("beat%0d_addr", beats), 32'(wr_addr), 32'((int'(base) + beats) % 512));
                beats++;
                if (inject && beats == 7 && !injected) begin
                    injected  = 1'b1;
                    start     = 1'b1;
                    col_major = ~col;
                    base_addr = 9'h100;
                    matriz_in = mat_b;
                end
            end
            prev_stall = wr_valid && !rdy;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            if (done) begin
                seen_done = 1'b1;
                dones++;
                check("done_after_last", 32'(beats), 32'(DIM * DIM));
                check("done_no_valid", 32'(wr_valid), 32'd0);
                if (timing) check("done_cycle", 32'(cyc), 32'd25);
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        start    = 1'b0;
        wr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) dones++;
            check("idle_no_valid", 32'(wr_valid), 32'd0);
        end
        check("single_done", 32'(dones), 32'd1);
        if (timing) check("busy_span", 32'(busy_cyc), 32'd26);
    endtask

    initial begin
        logic [ELEM_W-1:0] e;
        int beats;
        for (int rr = 0; rr < DIM; rr++) begin
            for (int cc = 0; cc < DIM; cc++) begin
                e = ELEM_W'(10 * rr + cc);
                mat_a[(DIM*ELEM_W*rr)+(ELEM_W*cc) +: ELEM_W] = e;
                e = ELEM_W'(8'hF0 - (rr * DIM + cc));
                mat_b[(DIM*ELEM_W*rr)+(ELEM_W*cc) +: ELEM_W] = e;
            end
        end
        rst_n = 1'b0; start = 1'b0; col_major = 1'b0; base_addr = '0;
        matriz_in = '0; wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stream(1'b0, 9'h020, 1'b0, 1'b0, 1'b1);
        run_stream(1'b1, 9'h000, 1'b0, 1'b0, 1'b1);
        run_stream(1'b0, 9'h040, 1'b1, 1'b0, 1'b0);
        run_stream(1'b1, 9'h0A0, 1'b1, 1'b0, 1'b0);
        run_stream(1'b0, 9'h1F0, 1'b0, 1'b0, 1'b1);
        run_stream(1'b0, 9'h060, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset while beat 12 is on the port
        pulse_start(1'b0, 9'h080);
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
            @(negedge clk);
            wr_ready = 1'b1;
            if (wr_valid) beats++;
        end
        @(negedge clk);
        check("pre_rst_valid", 32'(wr_valid), 32'd1);
        check("pre_rst_data", 32'(wr_data), 32'(exp_data(1'b0, 12)));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(wr_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        check("rst_hold_valid", 32'(wr_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_stream(1'b0, 9'h020, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
